video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse pixels.
REQ-004 SHALL have parameter H_BACK, default 48, back-porch pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, same meaning in lines.
REQ-006 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (1..16).
REQ-007 SHALL have parameters HS_POL and VS_POL, default 0, active sync level (0 = active-low).
REQ-008 SHALL have parameter CW, default 11, counter/coordinate width.
REQ-009 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-010 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-011 SHALL have port en, input, 1, timing run enable.
REQ-012 SHALL have port hsync, output, 1, horizontal sync at HS_POL level when active.
REQ-013 SHALL have port vsync, output, 1, vertical sync at VS_POL level when active.
REQ-014 SHALL have port video_on, output, 1, high inside the active region.
REQ-015 SHALL have port p_tick, output, 1, one-clk pixel-advance strobe.
REQ-016 SHALL have ports pixel_x and pixel_y, output, CW each, current coordinates.
REQ-017 SHALL have ports line_start and frame_start, output, 1 each, one-clk pulses.

Function
REQ-018 Divider SHALL count 0..CLK_DIV-1 and assert p_tick in the clk cycle where it equals CLK_DIV-1; CLK_DIV=1 gives p_tick high every cycle.
REQ-019 H counter SHALL advance on p_tick and wrap from H_TOTAL-1 (sum of four H params) to 0.
REQ-020 V counter SHALL advance only on p_tick with H counter at H_TOTAL-1, and wrap from V_TOTAL-1 to 0.
REQ-021 pixel_x/pixel_y SHALL equal the H/V counter registers directly.
REQ-022 hsync, vsync and video_on SHALL be registered and computed from the next counter values, so they change in the same cycle as pixel_x/pixel_y with no glitches.
REQ-023 hsync SHALL be active for H counter in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]; vsync likewise on the V counter.
REQ-024 video_on SHALL be high iff H < H_ACTIVE and V < V_ACTIVE.
REQ-025 line_start SHALL pulse for one clk in the cycle in which H becomes 0.
REQ-026 frame_start SHALL pulse for one clk in the cycle in which H and V both become 0.
REQ-027 When en=0, the block SHALL hold divider, H and V at 0, drive syncs inactive, and hold video_on, p_tick, line_start and frame_start low.
REQ-028 On the en 0->1 edge, the first p_tick SHALL occur CLK_DIV cycles later, with the position (0,0) displayed.
REQ-029 Deasserting en mid-frame SHALL return the block to the REQ-027 state in the next cycle; no partial frame is resumed.
REQ-030 Parameter checks SHALL fail elaboration if any porch/sync is 0, CLK_DIV is outside 1..16, or H_TOTAL/V_TOTAL does not fit in CW bits.

Reset
REQ-031 With reset high at a clk edge, outputs SHALL take: counters 0, divider 0, hsync=~HS_POL, vsync=~VS_POL, video_on=0, p_tick=0, line_start=0, frame_start=0.
REQ-032 Reset SHALL take priority over en.
REQ-033 After reset release with en=1, behaviour SHALL be identical to REQ-028.

Structure
REQ-034 Standard timing constants (640x480@60, 800x600@60) and the H_TOTAL/V_TOTAL calculation SHALL reside in the shared package video_timing_pkg.
REQ-035 One sub-module, timing_axis_counter (wrap counter with sync/active decode, instantiated twice: H and V), SHALL be used.

Verification
REQ-036 Use small parameters H=8/2/2/2, V=4/1/1/1, CLK_DIV=2, en=1 after reset -> p_tick every 2nd clk, pixel_x 0..13 wrap, pixel_y 0..6 wrap, frame of 196 clk.
REQ-037 Same config -> hsync low exactly for pixel_x 10..11, vsync low exactly for pixel_y 5, video_on high for x<8, y<4 only (32 pixels/frame).
REQ-038 CLK_DIV=1, HS_POL=VS_POL=1 -> p_tick constantly high, syncs active-high, frame_start period 98 clk.
REQ-039 Drop en at pixel (5,2) -> next cycle counters 0, syncs inactive, pulses low; re-raise en -> frame_start 2 clk later.
REQ-040 Assert reset mid-hsync at (11,3) -> next cycle all REQ-031 values, and counting restarts cleanly on release.
REQ-041 Default parameters -> 800x525 pixel frame, hsync at x 656..751, vsync at y 490..491, one frame_start per 840000 clk.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions.
// Contents: standard 640x480@60 / 800x600@60 axis constants, divider width,
// run-state encoding and the axis total helper used by the generator.
package video_timing_pkg;

  // Pixel divider width; covers CLK_DIV up to 16 (terminal count 15).
  localparam int unsigned DIV_W = 4;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock).
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FRONT  = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BACK   = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FRONT  = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BACK   = 33;

  // 800x600 @ 60 Hz (40 MHz pixel clock).
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FRONT  = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BACK   = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FRONT  = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BACK   = 23;

  // IDLE: held cleared; ARM: one cycle before pixel (0,0); RUN: counting.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } run_state_t;

  // Total count of one axis (active + front porch + sync + back porch).
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync_w,
                                             input int unsigned back);
    return active + front + sync_w + back;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis_counter: wrap counter for one video axis with sync decode.
// Ports: clk, reset (sync, active-high); clr forces count 0 / sync inactive;
// ld loads count 0 with normal decode; adv steps the count (wraps at TOTAL-1).
// cnt/sync are registered; active_nxt_c decodes the next count, at_end_c
// flags the terminal count.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter logic        POL    = 1'b0,
  parameter int unsigned CW     = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          sync,
  output logic          active_nxt_c,
  output logic          at_end_c
);

  localparam int unsigned TOTAL   = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int unsigned SYNC_LO = ACTIVE + FRONT;
  localparam int unsigned SYNC_HI = ACTIVE + FRONT + SYNC - 1;

  logic [CW-1:0] cnt_nxt;
  logic          in_sync_nxt;

  // Next count; outputs are decoded from it so they move together with cnt.
  always_comb begin
    cnt_nxt = cnt;
    if (clr || ld) begin
      cnt_nxt = '0;
    end else if (adv) begin
      cnt_nxt = at_end_c ? '0 : cnt + CW'(1);
    end
  end

  assign at_end_c     = (cnt == CW'(TOTAL - 1));
  assign active_nxt_c = (cnt_nxt < CW'(ACTIVE));
  assign in_sync_nxt  = (cnt_nxt >= CW'(SYNC_LO)) && (cnt_nxt <= CW'(SYNC_HI));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= (!clr && in_sync_nxt) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hsync/vsync/video_on/coordinates).
// Ports: clk; reset (sync, active-high, wins over en); en run enable;
// outputs hsync, vsync, video_on, p_tick, pixel_x, pixel_y, line_start,
// frame_start, all registered. The first clk edge with en high arms the block,
// the next one starts pixel (0,0) with line_start/frame_start; each pixel then
// lasts CLK_DIV clocks and p_tick marks its last clock.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Elaboration-time parameter sanity checks.
  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_chk_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
    $error("video_timing_gen: CLK_DIV must be in 1..16");
  end
  if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_chk_cw
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  run_state_t       state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             run_c;
  logic             start_c;
  logic             clr_c;
  logic             h_adv_c;
  logic             v_adv_c;
  logic             h_end_c;
  logic             v_end_c;
  logic             h_act_nxt_c;
  logic             v_act_nxt_c;

  // Control decode: clear while idle/disabled, load (0,0) on start, else count.
  always_comb begin
    run_c   = en && (state == ST_RUN);
    start_c = en && (state == ST_ARM);
    clr_c   = !en || (state == ST_IDLE);
    h_adv_c = run_c && (div == DIV_LAST);
    v_adv_c = h_adv_c && h_end_c;
    div_nxt = '0;
    if (run_c && (div != DIV_LAST)) begin
      div_nxt = div + DIV_W'(1);
    end
  end

  // Run FSM with divider and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      div         <= '0;
      video_on    <= 1'b0;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      video_on    <= (run_c || start_c) && h_act_nxt_c && v_act_nxt_c;
      p_tick      <= (run_c || start_c) && (div_nxt == DIV_LAST);
      line_start  <= start_c || (h_adv_c && h_end_c);
      frame_start <= start_c || (v_adv_c && v_end_c);
      case (state)
        ST_IDLE: if (en) state <= ST_ARM;
        ST_ARM:  state <= en ? ST_RUN : ST_IDLE;
        default: state <= en ? ST_RUN : ST_IDLE;
      endcase
    end
  end

  timing_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HS_POL),
    .CW     (CW)
  ) u_h (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr_c),
    .ld           (start_c),
    .adv          (h_adv_c),
    .cnt          (pixel_x),
    .sync         (hsync),
    .active_nxt_c (h_act_nxt_c),
    .at_end_c     (h_end_c)
  );

  timing_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VS_POL),
    .CW     (CW)
  ) u_v (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr_c),
    .ld           (start_c),
    .adv          (v_adv_c),
    .cnt          (pixel_y),
    .sync         (vsync),
    .active_nxt_c (v_act_nxt_c),
    .at_end_c     (v_end_c)
  );

endmodule
